buzzer_pattern_gen: RTL and testbench
=====================================

// Module: buzzer_pattern_gen
// PURPOSE
//  Parametrised two-tone buzzer sequencer for the medicine-kit reminder path.
//  Decodes the kit state code and drives a cadenced alarm tone: alternating A/B tone segments, then a silent gap, repeating.
//  Supports user acknowledge (silence until the alarm state clears) and an optional burst timeout.
//  Single clock domain; the tone dividers replace external frequency clocks.
// PARAMETERS
//  STATE_W        4        width of state_in
//  ALARM_MASK     16'h01C0 bit k set => state code k is an alarm state (default: codes 6, 7, 8); needs >= 2**STATE_W bits
//  TONE_A_DIV     2        tone A half-period in clk_base cycles (>=1); period = 2*TONE_A_DIV
//  TONE_B_DIV     4        tone B half-period in clk_base cycles (>=1)
//  SEG_LEN        8        cycles per tone segment (>=1)
//  PAIRS          2        A+B segment pairs per burst (>=1)
//  GAP_LEN        8        silent cycles between bursts (>=1)
//  TIMEOUT_BURSTS 4        bursts before auto-silence (used only with BUZZ_TIMEOUT_EN; >=1)
// PORTS
//  clk_base   in   1        system clock
//  rst_n      in   1        asynchronous reset, active low
//  state_in   in   STATE_W  kit state code
//  ack        in   1        user acknowledge, sampled each cycle, level or pulse
//  buzz_out   out  1        buzzer drive (flop output)
//  active     out  1        1 while FSM not IDLE (flop output)
//  timed_out  out  1        1 after timeout silenced the current alarm; tied 0 without BUZZ_TIMEOUT_EN
// BEHAVIOUR
//  Reset state (async, rst_n=0): FSM=IDLE; all counters 0; acked=0; buzz_out=0, active=0, timed_out=0.
//  alarm = ALARM_MASK[state_in] (combinational decode, registered consumers only).
//  FSM states:
//   - IDLE -> TONE_A when alarm & !acked.
//   - TONE_A -> TONE_B after SEG_LEN cycles.
//   - TONE_B -> TONE_A after SEG_LEN cycles when pairs_done < PAIRS-1; else -> GAP.
//   - GAP -> TONE_A after GAP_LEN cycles (pairs count cleared).
//   - From any non-IDLE state: -> IDLE if !alarm, or ack=1, or a timeout occurs.
//  Latency: alarm sampled high at edge t => at t+1 FSM=TONE_A, active=1, buzz_out=1.
//  Tone generation:
//   - On every edge entering TONE_A/TONE_B: buzz_out<=1, half counter<=0.
//   - Within a segment, buzz_out toggles when half counter == DIV-1; counter then reloads to 0.
//   - On any edge into GAP/IDLE: buzz_out<=0, so buzz_out is never 1 outside tone states.
//  Segment counter: 0..SEG_LEN-1 in tone states, 0..GAP_LEN-1 in GAP; width $clog2(max+1); wraps to 0 on every state change.
//  Acknowledge:
//   - ack=1 while active => IDLE next edge, buzz_out=0, acked<=1.
//   - ack while IDLE and alarm => acked<=1 (pre-silence); ack with !alarm is ignored.
//   - acked clears on the first cycle alarm=0; the next alarm restarts from TONE_A.
//  Simultaneous events:
//   - ack and alarm drop on the same edge => IDLE, acked=0 (alarm drop wins).
//   - state_in changing between two alarm codes => no restart; pattern continues uninterrupted.
//  Reset mid-tone: outputs 0 immediately (async); no residual tone after release until alarm is re-sampled.
// CONFIGURATION
//  BUZZ_TIMEOUT_EN defined:
//   - burst counter increments on each GAP->TONE_A transition and on GAP exit;
//   - on completion of burst number TIMEOUT_BURSTS (end of its GAP) => IDLE, acked<=1, timed_out<=1;
//   - timed_out clears together with acked when alarm=0;
//   - burst counter clears on entry to IDLE.
//  BUZZ_TIMEOUT_EN undefined: no burst counter; alarm sounds until ack or alarm clears; timed_out=0.
// TESTING (default parameters)
//  Reset: hold rst_n=0 with state_in=6 -> buzz_out=0, active=0; release -> TONE_A starts next edge.
//  state_in=6 from IDLE -> buzz_out 1 at t+1; toggles every 2 cycles for 8 cycles, every 4 cycles for 8,
//   repeat once; then 0 for 8 cycles; cycle repeats (40-cycle burst).
//  Non-alarm code: state_in=5 (and 0, 9, 15) for 200 cycles -> buzz_out=0, active=0 throughout.
//  Ack mid TONE_B with state_in=7 -> buzz_out=0, active=0 next edge; stays silent 100 cycles;
//   state_in=0 one cycle then 8 -> TONE_A restarts, buzz_out=1 next edge.
//  Code switch and async reset: state_in 6->7 mid TONE_A -> pattern unchanged;
//   rst_n=0 mid tone -> buzz_out=0 without a clock edge.
//  BUZZ_TIMEOUT_EN, TIMEOUT_BURSTS=2 -> exactly 2 bursts (80 cycles), then timed_out=1, buzz_out=0;
//   state_in=0 -> timed_out=0.

Source files
------------

// File: rtl/buzzer_pattern_gen.sv
// Two-tone cadenced buzzer sequencer: A/B tone segments, silent gap, repeat; ack silences until alarm clears.
// Optional burst timeout enabled by defining BUZZ_TIMEOUT_EN.
module buzzer_pattern_gen #(
  parameter int                        STATE_W        = 4,
  parameter logic [(2**STATE_W)-1:0]   ALARM_MASK     = 16'h01C0,
  parameter int                        TONE_A_DIV     = 2,
  parameter int                        TONE_B_DIV     = 4,
  parameter int                        SEG_LEN        = 8,
  parameter int                        PAIRS          = 2,
  parameter int                        GAP_LEN        = 8,
  parameter int                        TIMEOUT_BURSTS = 4
) (
  input  logic               clk_base,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_in,
  input  logic               ack,
  output logic               buzz_out,
  output logic               active,
  output logic               timed_out
);

  localparam int SEG_MAX = (SEG_LEN > GAP_LEN) ? SEG_LEN : GAP_LEN;
  localparam int DIV_MAX = (TONE_A_DIV > TONE_B_DIV) ? TONE_A_DIV : TONE_B_DIV;
  localparam int SEG_W   = $clog2(SEG_MAX + 1);
  localparam int HALF_W  = $clog2(DIV_MAX + 1);
  localparam int PAIR_W  = $clog2(PAIRS + 1);

  if (TONE_A_DIV < 1 || TONE_B_DIV < 1 || SEG_LEN < 1 || PAIRS < 1 ||
      GAP_LEN < 1 || TIMEOUT_BURSTS < 1) begin : g_param_err
    $error("buzzer_pattern_gen: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_TONE_A, S_TONE_B, S_GAP} state_t;

  state_t              r_state;
  logic [SEG_W-1:0]    r_seg;
  logic [HALF_W-1:0]   r_half;
  logic [PAIR_W-1:0]   r_pairs;
  logic                r_acked;
  logic                r_buzz;
  logic                r_active;

  logic                w_alarm;
  logic                w_seg_end;
  logic                w_gap_end;
  logic                w_timeout;
  logic [HALF_W-1:0]   w_div_last;

  assign w_alarm    = ALARM_MASK[state_in];
  assign w_seg_end  = (r_seg == SEG_W'(SEG_LEN - 1));
  assign w_gap_end  = (r_state == S_GAP) && (r_seg == SEG_W'(GAP_LEN - 1));
  assign w_div_last = (r_state == S_TONE_B) ? HALF_W'(TONE_B_DIV - 1) : HALF_W'(TONE_A_DIV - 1);

`ifdef BUZZ_TIMEOUT_EN
  localparam int BURST_W = $clog2(TIMEOUT_BURSTS + 1);
  logic [BURST_W-1:0] r_bursts;
  logic               r_timed_out;

  assign w_timeout = w_alarm && !ack && w_gap_end && (r_bursts == BURST_W'(TIMEOUT_BURSTS - 1));
  assign timed_out = r_timed_out;

  // Burst count restarts whenever the FSM drops back to IDLE.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      r_bursts    <= '0;
      r_timed_out <= 1'b0;
    end else if (!w_alarm) begin
      r_bursts    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_timeout) begin
      r_bursts    <= '0;
      r_timed_out <= 1'b1;
    end else if (ack && r_state != S_IDLE) begin
      r_bursts    <= '0;
    end else if (w_gap_end) begin
      r_bursts    <= r_bursts + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign buzz_out = r_buzz;
  assign active   = r_active;

  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_seg    <= '0;
      r_half   <= '0;
      r_pairs  <= '0;
      r_acked  <= 1'b0;
      r_buzz   <= 1'b0;
      r_active <= 1'b0;
    end else if (!w_alarm) begin
      // Alarm drop wins over a simultaneous ack: acked is cleared.
      r_state  <= S_IDLE;
      r_seg    <= '0;
      r_half   <= '0;
      r_pairs  <= '0;
      r_acked  <= 1'b0;
      r_buzz   <= 1'b0;
      r_active <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (ack) begin
        r_acked <= 1'b1;
      end else if (!r_acked) begin
        r_state  <= S_TONE_A;
        r_seg    <= '0;
        r_half   <= '0;
        r_pairs  <= '0;
        r_buzz   <= 1'b1;
        r_active <= 1'b1;
      end
    end else if (ack || w_timeout) begin
      r_state  <= S_IDLE;
      r_seg    <= '0;
      r_half   <= '0;
      r_pairs  <= '0;
      r_acked  <= 1'b1;
      r_buzz   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_TONE_A, S_TONE_B: begin
          if (w_seg_end) begin
            r_seg  <= '0;
            r_half <= '0;
            if (r_state == S_TONE_A) begin
              r_state <= S_TONE_B;
              r_buzz  <= 1'b1;
            end else if (r_pairs != PAIR_W'(PAIRS - 1)) begin
              r_state <= S_TONE_A;
              r_pairs <= r_pairs + 1'b1;
              r_buzz  <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_buzz  <= 1'b0;
            end
          end else begin
            r_seg <= r_seg + 1'b1;
            if (r_half == w_div_last) begin
              r_half <= '0;
              r_buzz <= ~r_buzz;
            end else begin
              r_half <= r_half + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_state <= S_TONE_A;
            r_seg   <= '0;
            r_half  <= '0;
            r_pairs <= '0;
            r_buzz  <= 1'b1;
          end else begin
            r_seg <= r_seg + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Randomized self-checking bench for buzzer_pattern_gen (default parameters) against a cadence-arithmetic model.
module tb_buzzer_pattern_gen;
  localparam int BURST_CYC = 40;
  localparam int TO_BURSTS = 4;

  logic       clk_base = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] state_in = 4'd0;
  logic       ack      = 1'b0;
  logic       buzz_out, active, timed_out;

  int checks   = 0;
  int failures = 0;

  // Model: running flag plus cycles elapsed since the alarm started sounding.
  bit m_run, m_acked, m_to;
  int m_k;

  logic [3:0] q_code[$];
  bit         q_ack[$];

  always #5 clk_base = ~clk_base;

  buzzer_pattern_gen dut (
    .clk_base (clk_base),
    .rst_n    (rst_n),
    .state_in (state_in),
    .ack      (ack),
    .buzz_out (buzz_out),
    .active   (active),
    .timed_out(timed_out)
  );

  function automatic bit is_alarm(logic [3:0] c);
    return (c >= 4'd6) && (c <= 4'd8);
  endfunction

  // Burst: A(8) B(8) A(8) B(8) gap(8); A half-period 2, B half-period 4, each segment starts high.
  function automatic bit pat(int k);
    int p, s, w, d;
    p = k % BURST_CYC;
    if (p >= 32) return 1'b0;
    s = p / 8;
    w = p % 8;
    d = (s % 2 == 0) ? 2 : 4;
    return ((w / d) % 2) == 0;
  endfunction

  function automatic logic [2:0] exp_out();
    return {m_run && pat(m_k), m_run, m_to};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_acked = 1'b0; m_to = 1'b0; m_k = 0;
  endtask

  task automatic tick(logic [3:0] c, bit a);
    state_in = c;
    ack      = a;
    @(posedge clk_base);
    if (!is_alarm(c)) begin
      m_run = 1'b0; m_acked = 1'b0; m_to = 1'b0;
    end else if (m_run) begin
      if (a) begin
        m_run = 1'b0; m_acked = 1'b1;
      end else begin
        m_k++;
`ifdef BUZZ_TIMEOUT_EN
        if (m_k == TO_BURSTS * BURST_CYC) begin
          m_run = 1'b0; m_acked = 1'b1; m_to = 1'b1;
        end
`endif
      end
    end else if (a) begin
      m_acked = 1'b1;
    end else if (!m_acked) begin
      m_run = 1'b1; m_k = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; state_in = 4'd6; ack = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_base); #1;
      checks++;
      if ({buzz_out, active, timed_out} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b want=000", i, {buzz_out, active, timed_out});
      end
    end
    @(negedge clk_base); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(4'd6, 1'b0);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_pattern();
    q_code.delete(); q_ack.delete();
    q_code.push_back(4'd0); q_ack.push_back(1'b0);
    for (int i = 0; i < 130; i++) begin q_code.push_back(4'd6); q_ack.push_back(1'b0); end
    for (int i = 0; i < q_code.size(); i++) begin
      tick(q_code[i], q_ack[i]);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL pattern cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_non_alarm();
    logic [3:0] codes [4];
    codes = '{4'd5, 4'd0, 4'd9, 4'd15};
    q_code.delete(); q_ack.delete();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 50; i++) begin q_code.push_back(codes[c]); q_ack.push_back(i == 10); end
    for (int i = 0; i < q_code.size(); i++) begin
      tick(q_code[i], q_ack[i]);
      checks++;
      if ({buzz_out, active} !== 2'b00 || {buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL non_alarm cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_ack();
    q_code.delete(); q_ack.delete();
    q_code.push_back(4'd0); q_ack.push_back(1'b0);
    for (int i = 0; i < 11; i++) begin q_code.push_back(4'd7); q_ack.push_back(1'b0); end
    q_code.push_back(4'd7); q_ack.push_back(1'b1);                 // ack mid TONE_B
    for (int i = 0; i < 100; i++) begin q_code.push_back(4'd7); q_ack.push_back(1'b0); end
    q_code.push_back(4'd0); q_ack.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin q_code.push_back(4'd8); q_ack.push_back(1'b0); end
    q_code.push_back(4'd0); q_ack.push_back(1'b1);                 // ack + alarm drop together
    q_code.push_back(4'd6); q_ack.push_back(1'b0);
    q_code.push_back(4'd0); q_ack.push_back(1'b0);
    q_code.push_back(4'd6); q_ack.push_back(1'b1);                 // pre-silence from IDLE
    for (int i = 0; i < 20; i++) begin q_code.push_back(4'd6); q_ack.push_back(1'b0); end
    for (int i = 0; i < q_code.size(); i++) begin
      tick(q_code[i], q_ack[i]);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL ack cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_code_switch();
    q_code.delete(); q_ack.delete();
    q_code.push_back(4'd0); q_ack.push_back(1'b0);
    for (int i = 0; i < 4; i++)  begin q_code.push_back(4'd6); q_ack.push_back(1'b0); end
    for (int i = 0; i < 30; i++) begin q_code.push_back(4'd7); q_ack.push_back(1'b0); end
    for (int i = 0; i < 15; i++) begin q_code.push_back(4'd8); q_ack.push_back(1'b0); end
    for (int i = 0; i < q_code.size(); i++) begin
      tick(q_code[i], q_ack[i]);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL code_switch cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    tick(4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick(4'd6, 1'b0);
    checks++;
    if (buzz_out !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%b want=1", buzz_out);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({buzz_out, active, timed_out} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got=%b want=000", {buzz_out, active, timed_out});
    end
    @(negedge clk_base); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(4'd6, 1'b0);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL async_release cyc=%0d got=%b want=%b", i, {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    int len;
    q_code.delete(); q_ack.delete();
    for (int s = 0; s < 30; s++) begin
      c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(6, 8));
      len = $urandom_range(1, 120);
      for (int i = 0; i < len; i++) begin
        q_code.push_back(c);
        q_ack.push_back($urandom_range(0, 59) == 0);
      end
    end
    for (int i = 0; i < q_code.size(); i++) begin
      tick(q_code[i], q_ack[i]);
      checks++;
      if ({buzz_out, active, timed_out} !== exp_out()) begin
        failures++;
        $display("FAIL random cyc=%0d code=%0d ack=%b got=%b want=%b",
                 i, q_code[i], q_ack[i], {buzz_out, active, timed_out}, exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pattern();
    test_non_alarm();
    test_ack();
    test_code_switch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
